// File: rtl/toy_eu_dispatch_fifo.sv
// Per-execution-unit input queue behind the dispatch crossbar: in-order circular buffer with
// valid/ready drain to the EU, almost-full throttle to issue select, and a sticky overflow flag.
package toy_eu_pkg;
    typedef struct packed {
        logic [7:0]  inst_id;
        logic [3:0]  opcode;
        logic [31:0] operand;
    } eu_pkg;
endpackage

module toy_eu_dispatch_fifo
    import toy_eu_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq_vld,
    input  eu_pkg            enq_pld,
    output logic             eu_vld,
    output eu_pkg            eu_pld,
    input  logic             eu_rdy,
    output logic             almost_full,
    output logic [CNT_W-1:0] occupancy,
    output logic             overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    eu_pkg             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full;
    logic              enq;
    logic              deq;
    logic              ovf;

    // Handshake: the head transfers when eu_vld && eu_rdy in a non-flush cycle; eu_vld and eu_pld
    // come only from registers, so the head stays put until it transfers or is flushed.
    assign full   = (count == CNT_W'(DEPTH));
    assign deq    = eu_vld && eu_rdy && !flush;
    assign enq    = enq_vld && !flush && (!full || deq);
    assign ovf    = enq_vld && full && !deq && !flush;

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            // Flush empties the queue but keeps the overflow record for debug.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (ovf) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && enq) mem[wr_ptr] <= enq_pld;
    end

    assign eu_vld      = (count != '0);
    assign eu_pld      = mem[rd_ptr];
    assign occupancy   = count;
    assign almost_full = ((CNT_W'(DEPTH) - count) <= CNT_W'(AF_MARGIN));

endmodule

// File: tb/tb_toy_eu_dispatch_fifo.sv
// Scenario bench for toy_eu_dispatch_fifo: directed fill/overflow/flush cases plus a long
// random run with issue honouring a one-cycle-delayed almost_full, all scored against a queue.
module tb_toy_eu_dispatch_fifo;
    import toy_eu_pkg::*;

    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             enq_vld = 1'b0;
    eu_pkg            enq_pld = '0;
    logic             eu_vld;
    eu_pkg            eu_pld;
    logic             eu_rdy = 1'b0;
    logic             almost_full;
    logic [CNT_W-1:0] occupancy;
    logic             overflow_err;

    eu_pkg exp_q[$];
    int    mc;
    logic  movf;
    int    n_checks = 0;
    int    n_fail   = 0;

    toy_eu_dispatch_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_vld(enq_vld), .enq_pld(enq_pld),
        .eu_vld(eu_vld), .eu_pld(eu_pld), .eu_rdy(eu_rdy),
        .almost_full(almost_full), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic eu_pkg mk(input logic [7:0] id);
        eu_pkg p;
        p.inst_id = id;
        p.opcode  = 4'($urandom_range(0, 15));
        p.operand = $urandom;
        return p;
    endfunction

    // One clock: drive inputs after negedge, score the handshake, step the model, check state.
    task automatic cycle(input logic en, input eu_pkg p, input logic rdy, input logic fl);
        logic  deq;
        eu_pkg exp;
        enq_vld = en;
        enq_pld = p;
        eu_rdy  = rdy;
        flush   = fl;
        n_checks++;
        if (eu_vld !== (mc != 0)) begin
            n_fail++;
            $display("FAIL eu_vld: got %0b expected %0b", eu_vld, (mc != 0));
        end
        deq = (mc != 0) && rdy && !fl;
        if (deq) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got id %0d expected nothing", eu_pld.inst_id);
            end else begin
                exp = exp_q.pop_front();
                if (eu_pld !== exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h expected %h", eu_pld, exp);
                end
            end
        end
        if (fl) begin
            exp_q.delete();
            mc = 0;
        end else begin
            if (en && (mc < DEPTH || deq)) begin
                exp_q.push_back(p);
                mc++;
            end else if (en) begin
                movf = 1'b1;
            end
            if (deq) mc--;
        end
        @(posedge clk);
        @(negedge clk);
        enq_vld = 1'b0;
        eu_rdy  = 1'b0;
        flush   = 1'b0;
        n_checks++;
        if (occupancy !== CNT_W'(mc)) begin
            n_fail++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, mc);
        end
        n_checks++;
        if (almost_full !== ((DEPTH - mc) <= AF_MARGIN)) begin
            n_fail++;
            $display("FAIL almost_full: got %0b expected %0b", almost_full, ((DEPTH - mc) <= AF_MARGIN));
        end
        n_checks++;
        if (overflow_err !== movf) begin
            n_fail++;
            $display("FAIL overflow_err: got %0b expected %0b", overflow_err, movf);
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        enq_vld = 1'b0;
        eu_rdy  = 1'b0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mc   = 0;
        movf = 1'b0;
    endtask

    task automatic fill_1_to_4();
        for (int i = 1; i <= 4; i++) cycle(1'b1, mk(8'(i)), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (eu_vld !== 1'b0 || occupancy !== '0 || almost_full !== 1'b0 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got vld=%0b occ=%0d af=%0b ovf=%0b expected all 0",
                     eu_vld, occupancy, almost_full, overflow_err);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, mk(8'(i)), 1'b0, 1'b0);
            n_checks++;
            if (occupancy !== CNT_W'(i) || almost_full !== (i >= 3)) begin
                n_fail++;
                $display("FAIL fill_%0d: got occ=%0d af=%0b expected occ=%0d af=%0b",
                         i, occupancy, almost_full, i, (i >= 3));
            end
            n_checks++;
            if (eu_pld.inst_id !== 8'd1) begin
                n_fail++;
                $display("FAIL fill_head_%0d: got id %0d expected 1", i, eu_pld.inst_id);
            end
        end
    endtask

    task automatic test_full_enq_deq();
        apply_reset();
        fill_1_to_4();
        cycle(1'b1, mk(8'd5), 1'b1, 1'b0);
        n_checks++;
        if (occupancy !== CNT_W'(4) || eu_pld.inst_id !== 8'd2 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_enq_deq: got occ=%0d head=%0d ovf=%0b expected occ=4 head=2 ovf=0",
                     occupancy, eu_pld.inst_id, overflow_err);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (eu_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL full_enq_deq_drain: got vld=%0b expected 0", eu_vld);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        fill_1_to_4();
        cycle(1'b1, mk(8'd9), 1'b0, 1'b0);
        n_checks++;
        if (overflow_err !== 1'b1 || occupancy !== CNT_W'(4) || eu_pld.inst_id !== 8'd1) begin
            n_fail++;
            $display("FAIL overflow: got ovf=%0b occ=%0d head=%0d expected ovf=1 occ=4 head=1",
                     overflow_err, occupancy, eu_pld.inst_id);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %0b expected 1", overflow_err);
        end
    endtask

    task automatic test_flush();
        eu_pkg p;
        apply_reset();
        cycle(1'b1, mk(8'd11), 1'b0, 1'b0);
        cycle(1'b1, mk(8'd12), 1'b0, 1'b0);
        cycle(1'b1, mk(8'd13), 1'b1, 1'b1);
        n_checks++;
        if (occupancy !== '0 || eu_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got occ=%0d vld=%0b expected occ=0 vld=0", occupancy, eu_vld);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (occupancy !== '0) begin
            n_fail++;
            $display("FAIL flush_enq_dropped: got occ=%0d expected 0", occupancy);
        end
        p = mk(8'd14);
        cycle(1'b1, p, 1'b0, 1'b0);
        n_checks++;
        if (eu_pld !== p) begin
            n_fail++;
            $display("FAIL flush_restart: got %h expected %h", eu_pld, p);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic       af_prev;
        logic       en;
        logic [7:0] id;
        apply_reset();
        af_prev = 1'b0;
        id      = 8'd0;
        for (int i = 0; i < 10000; i++) begin
            en = !af_prev && ($urandom_range(0, 3) != 0);
            af_prev = almost_full;
            cycle(en, mk(id), ($urandom_range(0, 2) != 0), 1'b0);
            if (en) id++;
        end
        while (mc != 0) cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (overflow_err !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_end: got ovf=%0b left=%0d expected ovf=0 left=0",
                     overflow_err, exp_q.size());
        end
    endtask

    initial begin
        mc   = 0;
        movf = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_enq_deq();
        test_overflow();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
